// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer with tagged out-of-order writeback
// Optional feature macro: ROB_BYPASS_EN (same-cycle commit of a writeback to the head entry)
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  output logic             alloc_ready,
  output logic [5:0]       alloc_tag,
  input  logic             wb_valid,
  input  logic [5:0]       wb_tag,
  input  logic [WIDTH-1:0] wb_data,
  output logic             commit_valid,
  output logic [4:0]       commit_rd,
  output logic [5:0]       commit_tag,
  output logic [WIDTH-1:0] commit_data,
  input  logic             commit_ready,
  input  logic             flush,
  output logic [6:0]       count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [6:0] DEPTH_C = 7'(DEPTH);

  logic             busy_q [DEPTH];
  logic             done_q [DEPTH];
  logic [4:0]       rd_q   [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [AW-1:0]    head_q;
  logic [AW-1:0]    tail_q;
  logic [6:0]       count_q;

  logic          wb_in_range;
  logic [AW-1:0] wb_idx;
  logic          wb_hit;
  logic          head_bypass;
  logic          do_alloc;
  logic          do_commit;

  // Tags wider than the buffer must not alias onto a real entry.
  assign wb_in_range = ({1'b0, wb_tag} < DEPTH_C);
  assign wb_idx      = wb_tag[AW-1:0];
  assign wb_hit      = wb_valid && wb_in_range && busy_q[wb_idx] && !done_q[wb_idx];

`ifdef ROB_BYPASS_EN
  assign head_bypass = wb_hit && (wb_idx == head_q);
`else
  assign head_bypass = 1'b0;
`endif

  assign alloc_ready  = (count_q < DEPTH_C);
  assign alloc_tag    = 6'(tail_q);
  assign commit_valid = busy_q[head_q] && (done_q[head_q] || head_bypass);
  assign commit_rd    = rd_q[head_q];
  assign commit_tag   = 6'(head_q);
  assign commit_data  = head_bypass ? wb_data : data_q[head_q];
  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == 7'd0);

  assign do_alloc  = alloc_valid && alloc_ready;
  assign do_commit = commit_valid && commit_ready;

  // Entry state, pointers and occupancy; reset and flush discard everything in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i] <= 1'b0;
        done_q[i] <= 1'b0;
        rd_q[i]   <= 5'd0;
        data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 7'd0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i] <= 1'b0;
        done_q[i] <= 1'b0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 7'd0;
    end else begin
      if (wb_hit) begin
        done_q[wb_idx] <= 1'b1;
        data_q[wb_idx] <= wb_data;
      end
      if (do_alloc) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        rd_q[tail_q]   <= alloc_rd;
        tail_q         <= tail_q + AW'(1);
      end
      // Retiring clears done as well, so a bypassed head never commits twice.
      if (do_commit) begin
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
        head_q         <= head_q + AW'(1);
      end
      case ({do_alloc, do_commit})
        2'b10:   count_q <= count_q + 7'd1;
        2'b01:   count_q <= count_q - 7'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;

  logic             clk;
  logic             reset_n;
  logic             alloc_valid;
  logic [4:0]       alloc_rd;
  logic             alloc_ready;
  logic [5:0]       alloc_tag;
  logic             wb_valid;
  logic [5:0]       wb_tag;
  logic [WIDTH-1:0] wb_data;
  logic             commit_valid;
  logic [4:0]       commit_rd;
  logic [5:0]       commit_tag;
  logic [WIDTH-1:0] commit_data;
  logic             commit_ready;
  logic             flush;
  logic [6:0]       count;
  logic             full;
  logic             empty;

  int checks;
  int failures;

  reorder_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_data(commit_data), .commit_ready(commit_ready),
    .flush(flush), .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid  = 1'b0;
    alloc_rd     = 5'd0;
    wb_valid     = 1'b0;
    wb_tag       = 6'd0;
    wb_data      = '0;
    commit_ready = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic alloc_one(input logic [4:0] rd);
    alloc_valid = 1'b1;
    alloc_rd    = rd;
    cyc();
    alloc_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_alloc_ready got=%0b exp=1", alloc_ready); end
    checks++; if (alloc_tag !== 6'd0) begin failures++; $display("FAIL reset_alloc_tag got=%0d exp=0", alloc_tag); end
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL reset_commit_valid got=%0b exp=0", commit_valid); end
    checks++; if (commit_rd !== 5'd0 || commit_tag !== 6'd0 || commit_data !== 32'd0) begin failures++; $display("FAIL reset_commit_fields got rd=%0d tag=%0d data=%0h exp all 0", commit_rd, commit_tag, commit_data); end
    checks++; if (count !== 7'd0 || empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_occupancy got count=%0d empty=%0b full=%0b exp 0/1/0", count, empty, full); end
  endtask

  task automatic test_alloc_basic();
    logic [4:0] rds [3];
    rds[0] = 5'd5; rds[1] = 5'd6; rds[2] = 5'd7;
    for (int i = 0; i < 3; i++) begin
      checks++; if (alloc_tag !== 6'(i)) begin failures++; $display("FAIL alloc_tag_%0d got=%0d exp=%0d", i, alloc_tag, i); end
      alloc_one(rds[i]);
    end
    checks++; if (count !== 7'd3) begin failures++; $display("FAIL alloc_count got=%0d exp=3", count); end
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL alloc_commit_valid got=%0b exp=0", commit_valid); end
  endtask

  task automatic test_wb_order();
    wb_valid = 1'b1; wb_tag = 6'd1; wb_data = 32'h1111_1111;
    cyc();
    wb_valid = 1'b0;
    #1;
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL wb_tail_only_commit_valid got=%0b exp=0", commit_valid); end
    wb_valid = 1'b1; wb_tag = 6'd0; wb_data = 32'h2222_0000;
    cyc();
    wb_valid = 1'b0;
    #1;
    checks++; if (commit_valid !== 1'b1 || commit_tag !== 6'd0 || commit_rd !== 5'd5 || commit_data !== 32'h2222_0000) begin failures++; $display("FAIL commit_first got v=%0b tag=%0d rd=%0d data=%0h exp 1/0/5/22220000", commit_valid, commit_tag, commit_rd, commit_data); end
    commit_ready = 1'b1;
    cyc();
    checks++; if (commit_valid !== 1'b1 || commit_tag !== 6'd1 || commit_rd !== 5'd6 || commit_data !== 32'h1111_1111) begin failures++; $display("FAIL commit_second got v=%0b tag=%0d rd=%0d data=%0h exp 1/1/6/11111111", commit_valid, commit_tag, commit_rd, commit_data); end
    cyc();
    commit_ready = 1'b0;
    #1;
    checks++; if (commit_valid !== 1'b0 || count !== 7'd1) begin failures++; $display("FAIL after_two_commits got v=%0b count=%0d exp 0/1", commit_valid, count); end
    // Out-of-range tag aliases onto index 2 (the busy head) and must be ignored.
    wb_valid = 1'b1; wb_tag = 6'd18; wb_data = 32'hBAD0_0002;
    cyc();
    wb_valid = 1'b0;
    #1;
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL wb_tag_out_of_range got v=%0b exp=0", commit_valid); end
    wb_valid = 1'b1; wb_tag = 6'd2; wb_data = 32'h0000_0777;
    cyc();
    wb_data = 32'h0000_0888;
    cyc();
    wb_valid = 1'b0;
    #1;
    checks++; if (commit_data !== 32'h0000_0777 || commit_rd !== 5'd7) begin failures++; $display("FAIL wb_to_done_ignored got data=%0h rd=%0d exp 777/7", commit_data, commit_rd); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (alloc_tag !== 6'(i)) begin failures++; $display("FAIL fill_tag_%0d got=%0d exp=%0d", i, alloc_tag, i); end
      alloc_one(5'(i + 1));
    end
    checks++; if (full !== 1'b1 || alloc_ready !== 1'b0 || count !== 7'd16) begin failures++; $display("FAIL full_flags got full=%0b ready=%0b count=%0d exp 1/0/16", full, alloc_ready, count); end
    alloc_one(5'd31);
    checks++; if (count !== 7'd16 || commit_rd !== 5'd1 || commit_tag !== 6'd0) begin failures++; $display("FAIL alloc_when_full got count=%0d rd=%0d tag=%0d exp 16/1/0", count, commit_rd, commit_tag); end
    wb_valid = 1'b1; wb_tag = 6'd0; wb_data = 32'hCAFE_0000;
    cyc();
    wb_valid = 1'b0;
    commit_ready = 1'b1; alloc_valid = 1'b1; alloc_rd = 5'd20;
    #1;
    checks++; if (commit_valid !== 1'b1) begin failures++; $display("FAIL full_head_commit_valid got=%0b exp=1", commit_valid); end
    cyc();
    commit_ready = 1'b0; alloc_valid = 1'b0;
    #1;
    checks++; if (count !== 7'd15 || full !== 1'b0 || alloc_tag !== 6'd0) begin failures++; $display("FAIL full_commit_blocks_alloc got count=%0d full=%0b tag=%0d exp 15/0/0", count, full, alloc_tag); end
    alloc_one(5'd21);
    checks++; if (count !== 7'd16 || full !== 1'b1 || commit_tag !== 6'd1) begin failures++; $display("FAIL wrap_alloc got count=%0d full=%0b head=%0d exp 16/1/1", count, full, commit_tag); end
  endtask

  task automatic test_hold();
    do_reset();
    alloc_one(5'd3);
    wb_valid = 1'b1; wb_tag = 6'd0; wb_data = 32'h0000_A5A5;
    cyc();
    wb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (commit_valid !== 1'b1 || commit_rd !== 5'd3 || commit_tag !== 6'd0 || commit_data !== 32'h0000_A5A5) begin failures++; $display("FAIL hold_cycle_%0d got v=%0b rd=%0d tag=%0d data=%0h exp 1/3/0/a5a5", i, commit_valid, commit_rd, commit_tag, commit_data); end
      cyc();
    end
    commit_ready = 1'b1;
    cyc();
    commit_ready = 1'b0;
    #1;
    checks++; if (commit_valid !== 1'b0 || empty !== 1'b1 || commit_tag !== 6'd1) begin failures++; $display("FAIL hold_release got v=%0b empty=%0b head=%0d exp 0/1/1", commit_valid, empty, commit_tag); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) alloc_one(5'(i + 10));
    wb_valid = 1'b1; wb_tag = 6'd0; wb_data = 32'h5555_5555;
    cyc();
    wb_valid = 1'b1; wb_tag = 6'd1; wb_data = 32'h6666_6666;
    alloc_valid = 1'b1; alloc_rd = 5'd30; commit_ready = 1'b1; flush = 1'b1;
    cyc();
    idle_inputs();
    #1;
    checks++; if (count !== 7'd0 || empty !== 1'b1 || alloc_tag !== 6'd0 || commit_valid !== 1'b0) begin failures++; $display("FAIL flush got count=%0d empty=%0b tag=%0d v=%0b exp 0/1/0/0", count, empty, alloc_tag, commit_valid); end
  endtask

  task automatic test_bypass();
    logic exp_same;
`ifdef ROB_BYPASS_EN
    exp_same = 1'b1;
`else
    exp_same = 1'b0;
`endif
    do_reset();
    alloc_one(5'd4);
    wb_valid = 1'b1; wb_tag = 6'd0; wb_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (commit_valid !== exp_same) begin failures++; $display("FAIL bypass_same_cycle got=%0b exp=%0b", commit_valid, exp_same); end
    cyc();
    wb_valid = 1'b0;
    #1;
    checks++; if (commit_valid !== 1'b1 || commit_data !== 32'hDEAD_BEEF || commit_rd !== 5'd4) begin failures++; $display("FAIL bypass_next_cycle got v=%0b data=%0h rd=%0d exp 1/deadbeef/4", commit_valid, commit_data, commit_rd); end
    commit_ready = 1'b1;
    cyc();
    commit_ready = 1'b0;
    alloc_one(5'd8);
    wb_valid = 1'b1; wb_tag = 6'd1; wb_data = 32'h1234_5678; commit_ready = 1'b1;
    cyc();
    wb_valid = 1'b0;
    #1;
    checks++; if (count !== (exp_same ? 7'd0 : 7'd1) || commit_valid !== !exp_same) begin failures++; $display("FAIL bypass_commit got count=%0d v=%0b exp %0d/%0b", count, commit_valid, exp_same ? 0 : 1, !exp_same); end
    cyc();
    commit_ready = 1'b0;
    #1;
    checks++; if (count !== 7'd0 || commit_valid !== 1'b0) begin failures++; $display("FAIL bypass_no_duplicate got count=%0d v=%0b exp 0/0", count, commit_valid); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_alloc_basic();
    test_wb_order();
    test_full();
    test_hold();
    test_flush();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the entry count; legal values are powers of two from 2 to 64.
REQ-002 SHALL have parameter WIDTH, default 32, meaning the result data width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port alloc_valid, input, 1 bit: decode requests an entry.
REQ-006 SHALL have port alloc_rd, input, 5 bits: destination architectural register.
REQ-007 SHALL have port alloc_ready, output, 1 bit: an entry is free.
REQ-008 SHALL have port alloc_tag, output, 6 bits: tag granted, equal to the tail index.
REQ-009 SHALL have port wb_valid, input, 1 bit: result broadcast.
REQ-010 SHALL have port wb_tag, input, 6 bits: tag of the result.
REQ-011 SHALL have port wb_data, input, WIDTH bits: result value.
REQ-012 SHALL have port commit_valid, output, 1 bit: the head entry is ready to retire.
REQ-013 SHALL have port commit_rd, output, 5 bits: head destination register.
REQ-014 SHALL have port commit_tag, output, 6 bits: head tag.
REQ-015 SHALL have port commit_data, output, WIDTH bits: head result.
REQ-016 SHALL have port commit_ready, input, 1 bit: the register file accepts the retirement.
REQ-017 SHALL have port flush, input, 1 bit: discard all entries.
REQ-018 SHALL have port count, output, 7 bits: occupied entries.
REQ-019 SHALL have ports full and empty, outputs, 1 bit each: occupancy flags.

Function
REQ-020 SHALL hold per entry: busy, done, rd[4:0], data[WIDTH-1:0]; plus head pointer, tail pointer and count.
REQ-021 SHALL set alloc_ready = (count < DEPTH) and drive alloc_tag = tail, both from registered state only.
REQ-022 SHALL, on alloc_valid && alloc_ready, write entry[tail] as busy=1, done=0, rd=alloc_rd, and set tail = (tail+1) mod DEPTH.
REQ-023 SHALL allocate normally when alloc_rd = 0; the entry retires with commit_rd = 0.
REQ-024 SHALL, on wb_valid where entry[wb_tag] is busy and not done, set done=1 and data=wb_data; a writeback to a free entry, a done entry, or a tag >= DEPTH SHALL be ignored.
REQ-025 SHALL drive commit_valid = entry[head].busy && entry[head].done, and commit_rd/commit_tag/commit_data from entry[head].
REQ-026 SHALL, on commit_valid && commit_ready, clear entry[head].busy and set head = (head+1) mod DEPTH.
REQ-027 SHALL keep commit outputs stable while commit_valid=1 && commit_ready=0.
REQ-028 SHALL wrap the pointers from DEPTH-1 to 0 with no gap.
REQ-029 SHALL update count by +1 on alloc only, -1 on commit only, and 0 on both or neither.
REQ-030 SHALL block allocation in a cycle where count = DEPTH, even if a commit occurs in the same cycle.
REQ-031 SHALL process a writeback and a commit to different entries in the same cycle independently.
REQ-032 SHALL process a writeback to the head entry so that commit_valid rises the next cycle (baseline latency 1).
REQ-033 SHALL give flush priority over alloc, wb and commit: on the next edge all busy=0, head=tail=0, count=0.
REQ-034 SHALL set full = (count == DEPTH) and empty = (count == 0).

Reset
REQ-035 SHALL, on a clock edge with reset_n=0, clear all busy/done/rd/data, set head=tail=count=0, and override every other input.
REQ-036 SHALL, after reset, drive alloc_ready=1, alloc_tag=0, commit_valid=0, commit_rd=0, commit_tag=0, commit_data=0, count=0, empty=1, full=0.
REQ-037 SHALL, if reset is asserted mid-operation, discard all in-flight entries exactly as flush does.

Configuration
REQ-038 SHALL support macro ROB_BYPASS_EN: when defined, a valid writeback targeting a busy, not-done head entry asserts commit_valid in the same cycle, with commit_data = wb_data; when undefined, REQ-032 latency applies.
REQ-039 SHALL, with ROB_BYPASS_EN defined and a bypass commit accepted, retire the head without a later duplicate commit.

Verification
REQ-040 SHALL cover: reset, then 3 allocs with rd=5,6,7 -> alloc_tag 0,1,2; count=3; commit_valid=0.
REQ-041 SHALL cover: wb tag1 then tag0, commit_ready=1 -> commits in order tag0 then tag1, rd 5 then 6, with matching data.
REQ-042 SHALL cover: 16 allocs -> full=1, alloc_ready=0; a 17th alloc_valid is ignored; a commit frees one entry; the next alloc gets tag 0 (wrap).
REQ-043 SHALL cover: commit_ready=0 with head done -> commit outputs held for 3 cycles; head advances when commit_ready=1.
REQ-044 SHALL cover: flush with 5 entries and simultaneous alloc/wb -> next cycle count=0, empty=1, alloc_tag=0.
REQ-045 SHALL cover: wb to the head with data 0xDEADBEEF -> commit_valid on the same cycle with ROB_BYPASS_EN defined, one cycle later without it.
